// File: rtl/demux8_router.sv
// 1-to-8 word distributor: one valid/ready input, eight single-register output lanes.
// Unicast loads the lane named by in_sel; broadcast loads all lanes or none.
module demux8_router #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic                 in_bcast,
    input  logic [WIDTH-1:0]     in_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     xfer_count
);

    // Handshake: a word moves on a port at a rising edge where valid & ready are
    // both high; valid never waits on ready, and in_ready never looks at in_valid.
    localparam logic [0:0] LANE_EMPTY = 1'b0;
    localparam logic [0:0] LANE_FULL  = 1'b1;

    logic [7:0]       r_full;
    logic [WIDTH-1:0] r_data [8];
    logic [CNT_W-1:0] r_count;

    logic [7:0]       w_can_take;
    logic [7:0]       w_drain;
    logic [7:0]       w_load;
    logic             w_in_ready;
    logic             w_accept;

    // A lane being drained this cycle may reload at the same edge.
    assign w_can_take = ~r_full | out_ready;
    assign w_drain    = r_full & out_ready;
    assign w_in_ready = in_bcast ? (&w_can_take) : w_can_take[in_sel];
    assign w_accept   = in_valid & w_in_ready;

    always_comb begin
        w_load = '0;
        for (int k = 0; k < 8; k++) begin
            w_load[k] = w_accept & (in_bcast | (in_sel == 3'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= {8{LANE_EMPTY}};
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_load[k]) begin
                    r_full[k] <= LANE_FULL;
                end else if (w_drain[k]) begin
                    r_full[k] <= LANE_EMPTY;
                end
            end
        end
    end

    // Lane data is only written on load, so it holds while stalled and after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane_out
        assign out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_full;
    assign busy       = |r_full;
    assign xfer_count = r_count;

endmodule

// File: tb/tb_demux8_router.sv
// Bench for demux8_router: directed table, corner sequences and random traffic
// checked against a lane-array model; a CNT_W=4 twin shares the stimulus for wrap.
module tb_demux8_router;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [2:0]     in_sel;
    logic           in_bcast;
    logic [W-1:0]   in_data;
    logic [7:0]     out_ready;
    logic           in_ready;
    logic [7:0]     out_valid;
    logic [8*W-1:0] out_data;
    logic           busy;
    logic [15:0]    xfer_count;
    logic           in_ready4;
    logic [7:0]     out_valid4;
    logic [8*W-1:0] out_data4;
    logic           busy4;
    logic [3:0]     xfer_count4;

    demux8_router #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .xfer_count(xfer_count)
    );

    demux8_router #(.WIDTH(W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .busy(busy4), .xfer_count(xfer_count4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: each lane is one slot holding a word and a full flag
    logic         m_full [8];
    logic [W-1:0] m_data [8];
    int           m_count;
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic       valid;
        logic [2:0] sel;
        logic       bcast;
        logic [W-1:0] data;
        logic [7:0] ordy;
        logic       exp_ready;
        logic [7:0] exp_valid;
        int         chk_lane;
        logic [W-1:0] exp_word;
        int         exp_count;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        m_count = 0;
    endtask

    function automatic logic model_ready();
        int ok;
        ok = 0;
        if (in_bcast) begin
            for (int k = 0; k < 8; k++) if (!m_full[k] || out_ready[k]) ok++;
            return (ok == 8);
        end
        return (!m_full[in_sel] || out_ready[in_sel]);
    endfunction

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic logic [8*W-1:0] model_data();
        logic [8*W-1:0] d;
        for (int k = 0; k < 8; k++) d[k*W +: W] = m_data[k];
        return d;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(model_valid()));
        chk({tag, ".out_data"}, 128'(out_data), 128'(model_data()));
        chk({tag, ".busy"}, 128'(busy), 128'(model_valid() != 8'h00));
        chk({tag, ".count"}, 128'(xfer_count), 128'(m_count % 65536));
        chk({tag, ".count4"}, 128'(xfer_count4), 128'(m_count % 16));
    endtask

    // one clock cycle; entered and left at posedge+1 with inputs already driven
    task automatic tick(input string tag, output logic rdy_seen);
        logic acc;
        logic [W-1:0] d;
        #3;
        rdy_seen = in_ready;
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(model_ready()));
        chk({tag, ".in_ready4"}, 128'(in_ready4), 128'(model_ready()));
        acc = in_valid && model_ready();
        d = in_data;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            if (acc && (in_bcast || in_sel == 3'(k))) begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end else if (out_ready[k]) begin
                m_full[k] = 1'b0;
            end
        end
        if (acc) m_count++;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic b,
                         input logic [W-1:0] d, input logic [7:0] r);
        in_valid  = v;
        in_sel    = s;
        in_bcast  = b;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs [8];
    logic rdy;
    logic hold;

    initial begin
        // reset with random inputs
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  W'($urandom), 8'($urandom));
            #4;
            chk("reset.in_ready", 128'(in_ready), 128'(1));
            chk("reset.out_valid", 128'(out_valid), 128'(0));
            chk("reset.busy", 128'(busy), 128'(0));
            chk("reset.count", 128'(xfer_count), 128'(0));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);

        // directed table: unicast, backpressure, independence, broadcast all-or-nothing
        vecs[0] = '{1'b1, 3'd5, 1'b0, 16'hBEEF, 8'h00, 1'b1, 8'h20, 5, 16'hBEEF, 1};
        vecs[1] = '{1'b1, 3'd3, 1'b0, 16'h1111, 8'h00, 1'b1, 8'h28, 3, 16'h1111, 2};
        vecs[2] = '{1'b1, 3'd3, 1'b0, 16'h2222, 8'h00, 1'b0, 8'h28, 3, 16'h1111, 2};
        vecs[3] = '{1'b1, 3'd4, 1'b0, 16'h4444, 8'h00, 1'b1, 8'h38, 4, 16'h4444, 3};
        vecs[4] = '{1'b0, 3'd0, 1'b0, 16'h0000, 8'h20, 1'b1, 8'h18, 5, 16'hBEEF, 3};
        vecs[5] = '{1'b1, 3'd0, 1'b1, 16'hA5A5, 8'h00, 1'b0, 8'h18, 0, 16'h0000, 3};
        vecs[6] = '{1'b1, 3'd0, 1'b1, 16'hA5A5, 8'h18, 1'b1, 8'hFF, 0, 16'hA5A5, 4};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF, 1'b1, 8'h00, 6, 16'hA5A5, 4};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].valid, vecs[i].sel, vecs[i].bcast, vecs[i].data, vecs[i].ordy);
            tick($sformatf("vec%0d", i), rdy);
            chk($sformatf("vec%0d.tbl_ready", i), 128'(rdy), 128'(vecs[i].exp_ready));
            chk($sformatf("vec%0d.tbl_valid", i), 128'(out_valid), 128'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.tbl_word", i), 128'(out_data[vecs[i].chk_lane*W +: W]),
                128'(vecs[i].exp_word));
            chk($sformatf("vec%0d.tbl_count", i), 128'(xfer_count), 128'(vecs[i].exp_count));
        end

        // broadcast released by the stalled lane draining in the same cycle
        do_reset();
        drive(1'b1, 3'd6, 1'b0, 16'h6666, 8'h00);
        tick("bc_fill", rdy);
        drive(1'b1, 3'd0, 1'b1, 16'hA5A5, 8'h00);
        tick("bc_stall", rdy);
        chk("bc_stall.ready", 128'(rdy), 128'(0));
        chk("bc_stall.lane6", 128'(out_data[6*W +: W]), 128'(16'h6666));
        drive(1'b1, 3'd0, 1'b1, 16'hA5A5, 8'h40);
        tick("bc_go", rdy);
        chk("bc_go.ready", 128'(rdy), 128'(1));
        chk("bc_go.valid", 128'(out_valid), 128'(8'hFF));
        chk("bc_go.all", 128'(out_data), 128'({8{16'hA5A5}}));

        // streaming 100 words into lane 2
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 3'd2, 1'b0, W'(i), 8'hFF);
            exp_q.push_back(W'(i));
            tick("stream", rdy);
            chk("stream.ready", 128'(rdy), 128'(1));
            chk("stream.lane2", 128'(out_data[2*W +: W]), 128'(exp_q.pop_front()));
        end
        drive(1'b0, 3'd2, 1'b0, '0, 8'hFF);
        tick("stream_end", rdy);
        chk("stream.count100", 128'(xfer_count), 128'(100));

        // counter wrap on the CNT_W=4 twin
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'(i % 8), 1'b0, W'($urandom), 8'hFF);
            tick("wrap", rdy);
        end
        chk("wrap.count4_zero", 128'(xfer_count4), 128'(0));
        chk("wrap.count16", 128'(xfer_count), 128'(16));

        // asynchronous reset mid-cycle with lanes 0,1,7 full
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 16'h0A0A, 8'h00);
        tick("mid_l0", rdy);
        drive(1'b1, 3'd1, 1'b0, 16'h1B1B, 8'h00);
        tick("mid_l1", rdy);
        drive(1'b1, 3'd7, 1'b0, 16'h7C7C, 8'h00);
        tick("mid_l7", rdy);
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        chk("mid.pre_valid", 128'(out_valid), 128'(8'h83));
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid.valid", 128'(out_valid), 128'(0));
        chk("mid.busy", 128'(busy), 128'(0));
        chk("mid.data", 128'(out_data), 128'(0));
        chk("mid.count", 128'(xfer_count), 128'(0));
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic; an unaccepted offer is held until taken
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 3'($urandom_range(0, 7));
                in_bcast = ($urandom_range(0, 9) == 0);
                in_data  = W'($urandom);
            end
            out_ready = 8'($urandom);
            tick("rand", rdy);
            hold = in_valid && !rdy;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
